memory_arbiter: RTL and testbench

Arbitrates the single-ported main RAM between the processor's instruction fetch path and data access path. Requests come from the request unit; this block sequences each access against the RAM's `ramstate` handshake and returns a one-cycle hit with registered load data. Data has priority, with an anti-starvation counter for instruction fetch. Bounded retry on RAM error, with a sticky fault flag.

---
 rtl/memory_arbiter.sv | 149 ++++++++++++++
 tb/tb_memory_arbiter.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_arbiter.sv
// rtl/memory_arbiter.sv - single-port RAM arbiter between instruction fetch and data access
//
// Sequences one RAM access at a time against the ramstate handshake.
// Data wins by default. Instruction fetch is forced through after
// STARVE_LIMIT consecutive data grants made while a fetch was pending.
// A RAM error causes the access to be retried. When the retries run out,
// the arbiter stops in a sticky fault state that only RST clears.
//
// Ports:
//   CLK, RST               rising-edge clock, asynchronous active-high reset
//   iREN, iaddr            instruction read request (held until ihit) and address
//   ihit, iload            one-cycle completion pulse and registered fetch data
//   dREN, dWEN             data read / write request (held until dhit); both high = write
//   daddr, dstore          data address and write data
//   dhit, dload            one-cycle completion pulse and registered load data
//   ramREN, ramWEN         RAM strobes, driven from registers latched at grant
//   ramaddr, ramstore      RAM address and write data, latched at grant
//   ramload, ramstate      RAM read data and handshake (FREE, BUSY, ACCESS, ERROR)
//   fault                  sticky: an access exhausted its retries
module memory_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int MAX_RETRY    = 3
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        ihit,
  output logic [31:0] iload,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dhit,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate,
  output logic        fault
);

  typedef enum logic [1:0] {FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2, ERROR = 2'd3} ramstate_t;
  typedef enum logic [1:0] {IDLE, DACC, IACC, FAULT} state_t;

  // Counter widths leave room for the limit value itself, even when the limit is zero.
  localparam int SW = $clog2(STARVE_LIMIT + 2);
  localparam int RW = $clog2(MAX_RETRY + 2);

  state_t    state;
  ramstate_t rs;
  logic [SW-1:0] starve_cnt;
  logic [RW-1:0] retry_cnt;

  logic i_req;
  logic d_req;
  logic d_wins;
  logic starved;

  assign rs = ramstate_t'(ramstate);

  // A requester whose hit is high this cycle is still holding its old request.
  // Masking it prevents a second grant for the same access.
  assign i_req   = iREN & ~ihit;
  assign d_req   = (dREN | dWEN) & ~dhit;
  assign starved = i_req & (starve_cnt == SW'(STARVE_LIMIT));
  assign d_wins  = d_req & ~starved;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= IDLE;
      starve_cnt <= '0;
      retry_cnt  <= '0;
      ihit       <= 1'b0;
      iload      <= '0;
      dhit       <= 1'b0;
      dload      <= '0;
      ramREN     <= 1'b0;
      ramWEN     <= 1'b0;
      ramaddr    <= '0;
      ramstore   <= '0;
      fault      <= 1'b0;
    end else begin
      ihit <= 1'b0;
      dhit <= 1'b0;
      case (state)
        IDLE: begin
          if (d_wins) begin
            state    <= DACC;
            ramaddr  <= daddr;
            ramstore <= dstore;
            ramWEN   <= dWEN;
            ramREN   <= ~dWEN;
            if (!i_req)
              starve_cnt <= '0;
            else if (starve_cnt != SW'(STARVE_LIMIT))
              starve_cnt <= starve_cnt + 1'b1;
          end else if (i_req) begin
            state      <= IACC;
            ramaddr    <= iaddr;
            ramstore   <= '0;
            ramREN     <= 1'b1;
            ramWEN     <= 1'b0;
            starve_cnt <= '0;
          end
        end
        DACC, IACC: begin
          case (rs)
            ACCESS: begin
              if (state == IACC) begin
                ihit  <= 1'b1;
                iload <= ramload;
              end else begin
                dhit <= 1'b1;
                if (!ramWEN)
                  dload <= ramload;
              end
              ramREN    <= 1'b0;
              ramWEN    <= 1'b0;
              retry_cnt <= '0;
              state     <= IDLE;
            end
            ERROR: begin
              // Strobes stay up on an error, so the RAM sees the same access again.
              if (retry_cnt == RW'(MAX_RETRY)) begin
                state  <= FAULT;
                ramREN <= 1'b0;
                ramWEN <= 1'b0;
                fault  <= 1'b1;
              end else begin
                retry_cnt <= retry_cnt + 1'b1;
              end
            end
            default: ;
          endcase
        end
        FAULT: begin
          ramREN <= 1'b0;
          ramWEN <= 1'b0;
          fault  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// tb/tb_memory_arbiter.sv - self-checking bench for memory_arbiter against a transaction-level model
module tb_memory_arbiter;

  localparam int STARVE_LIMIT = 4;
  localparam int MAX_RETRY    = 3;
  localparam logic [1:0] RS_FREE = 2'd0, RS_BUSY = 2'd1, RS_ACCESS = 2'd2, RS_ERROR = 2'd3;

  logic        CLK, RST;
  logic        iREN, dREN, dWEN;
  logic [31:0] iaddr, daddr, dstore, ramload;
  logic [1:0]  ramstate;
  logic        ihit, dhit, ramREN, ramWEN, fault;
  logic [31:0] iload, dload, ramaddr, ramstore;

  memory_arbiter #(.STARVE_LIMIT(STARVE_LIMIT), .MAX_RETRY(MAX_RETRY)) dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .iaddr(iaddr), .ihit(ihit), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dhit(dhit), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .fault(fault)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h at %0t", tag, got, want, $time);
    end
  endtask

  // Reference model: who owns the RAM (0 none, 1 fetch, 2 data, 3 dead),
  // plus the expected value of every output.
  int          owner, starve, retries;
  logic        e_ihit, e_dhit, e_ren, e_wen, e_fault;
  logic [31:0] e_iload, e_dload, e_addr, e_store;

  task automatic model_reset();
    owner = 0; starve = 0; retries = 0;
    e_ihit = 0; e_dhit = 0; e_ren = 0; e_wen = 0; e_fault = 0;
    e_iload = 0; e_dload = 0; e_addr = 0; e_store = 0;
  endtask

  task automatic model_step();
    bit iw, dw;
    iw = iREN && !e_ihit;
    dw = (dREN || dWEN) && !e_dhit;
    e_ihit = 0;
    e_dhit = 0;
    if (owner == 0) begin
      if (dw && !(iw && starve == STARVE_LIMIT)) begin
        owner = 2; e_wen = dWEN; e_ren = !dWEN; e_addr = daddr; e_store = dstore;
        starve = iw ? ((starve < STARVE_LIMIT) ? starve + 1 : starve) : 0;
      end else if (iw) begin
        owner = 1; e_ren = 1; e_wen = 0; e_addr = iaddr; e_store = 0; starve = 0;
      end
    end else if (owner == 1 || owner == 2) begin
      if (ramstate == RS_ACCESS) begin
        if (owner == 1) begin
          e_ihit = 1; e_iload = ramload;
        end else begin
          e_dhit = 1;
          if (!e_wen) e_dload = ramload;
        end
        e_ren = 0; e_wen = 0; retries = 0; owner = 0;
      end else if (ramstate == RS_ERROR) begin
        if (retries == MAX_RETRY) begin
          owner = 3; e_ren = 0; e_wen = 0; e_fault = 1;
        end else begin
          retries++;
        end
      end
    end
  endtask

  task automatic compare_all();
    check("ihit",     32'(ihit),   32'(e_ihit));
    check("dhit",     32'(dhit),   32'(e_dhit));
    check("iload",    iload,       e_iload);
    check("dload",    dload,       e_dload);
    check("ramREN",   32'(ramREN), 32'(e_ren));
    check("ramWEN",   32'(ramWEN), 32'(e_wen));
    check("ramaddr",  ramaddr,     e_addr);
    check("ramstore", ramstore,    e_store);
    check("fault",    32'(fault),  32'(e_fault));
    check("hit_excl", 32'(ihit & dhit), 32'd0);
  endtask

  // Called at a falling edge with inputs already set; returns at the next falling edge.
  task automatic tick();
    @(posedge CLK);
    model_step();
    @(negedge CLK);
    compare_all();
  endtask

  task automatic do_reset();
    #2 RST = 1'b1;
    #1;
    model_reset();
    compare_all();
    @(negedge CLK);
    RST = 1'b0;
  endtask

  task automatic idle_inputs();
    iREN = 0; dREN = 0; dWEN = 0; ramstate = RS_FREE;
  endtask

  logic [31:0] held;
  int          dcount;
  bit          got_ihit;
  int          r;

  initial begin
    RST = 1'b1;
    iaddr = 0; daddr = 0; dstore = 0; ramload = 0;
    idle_inputs();
    @(negedge CLK);
    model_reset();
    compare_all();
    RST = 1'b0;

    // Fetch with two BUSY cycles before ACCESS.
    iREN = 1; iaddr = 32'h40; ramstate = RS_FREE;
    tick();
    check("t1_ren_c1", 32'(ramREN), 32'd1);
    check("t1_addr_c1", ramaddr, 32'h40);
    ramstate = RS_BUSY;
    tick();
    tick();
    check("t1_ren_c3", 32'(ramREN), 32'd1);
    check("t1_hit_c3", 32'(ihit), 32'd0);
    ramstate = RS_ACCESS; ramload = 32'h8C010004;
    tick();
    check("t1_ihit_c4", 32'(ihit), 32'd1);
    check("t1_iload_c4", iload, 32'h8C010004);
    iREN = 0; ramstate = RS_FREE;
    tick();
    check("t1_ihit_c5", 32'(ihit), 32'd0);

    // Simultaneous requests: data first, then fetch, with no repeated data grant.
    iREN = 1; iaddr = 32'h0; dREN = 1; daddr = 32'h200; ramstate = RS_ACCESS; ramload = 32'h11112222;
    tick();
    check("t2_daddr", ramaddr, 32'h200);
    ramload = 32'h33334444;
    tick();
    check("t2_dhit", 32'(dhit), 32'd1);
    tick();
    dREN = 0;
    check("t2_iaddr", ramaddr, 32'h0);
    check("t2_ren", 32'(ramREN), 32'd1);
    tick();
    check("t2_ihit", 32'(ihit), 32'd1);
    iREN = 0;
    tick();

    // Starvation: fetch held except while dhit is showing.
    do_reset();
    dREN = 1; daddr = 32'h200; iaddr = 32'h0; iREN = 1; ramstate = RS_ACCESS;
    dcount = 0; got_ihit = 0;
    for (int k = 0; k < 40 && !got_ihit; k++) begin
      iREN = !dhit;
      tick();
      if (dhit) dcount++;
      if (ihit) got_ihit = 1;
    end
    check("t3_ihit_seen", 32'(got_ihit), 32'd1);
    check("t3_data_grants", 32'(dcount), 32'(STARVE_LIMIT));
    idle_inputs();
    tick();
    tick();

    // Write with live inputs scrambled after grant.
    held = dload;
    dWEN = 1; daddr = 32'h100; dstore = 32'hDEADBEEF; ramstate = RS_FREE;
    tick();
    daddr = 32'h5555AAAA; dstore = 32'h12345678; ramstate = RS_BUSY;
    tick();
    tick();
    check("t4_wen", 32'(ramWEN), 32'd1);
    check("t4_addr", ramaddr, 32'h100);
    check("t4_store", ramstore, 32'hDEADBEEF);
    ramstate = RS_ACCESS; ramload = 32'hCAFEF00D;
    tick();
    check("t4_dhit", 32'(dhit), 32'd1);
    check("t4_dload_kept", dload, held);
    idle_inputs();
    tick();

    // Two errors recover; four errors fault.
    dREN = 1; daddr = 32'h300;
    tick();
    ramstate = RS_ERROR;
    tick();
    tick();
    ramstate = RS_ACCESS; ramload = 32'h0BADF00D;
    tick();
    check("t5_dhit", 32'(dhit), 32'd1);
    check("t5_dload", dload, 32'h0BADF00D);
    check("t5_no_fault", 32'(fault), 32'd0);
    dREN = 0; iREN = 1; iaddr = 32'h44; ramstate = RS_FREE;
    tick();
    ramstate = RS_ERROR;
    for (int k = 0; k < MAX_RETRY; k++) tick();
    check("t5_ren_retrying", 32'(ramREN), 32'd1);
    tick();
    check("t5_fault", 32'(fault), 32'd1);
    check("t5_ren_dead", 32'(ramREN), 32'd0);
    dREN = 1; ramstate = RS_ACCESS;
    for (int k = 0; k < 4; k++) tick();
    check("t5_stuck", 32'(ramREN | ramWEN | ihit | dhit), 32'd0);
    idle_inputs();
    do_reset();

    // Asynchronous reset mid-fetch, then a clean fetch.
    iREN = 1; iaddr = 32'h80; ramstate = RS_FREE;
    tick();
    ramstate = RS_BUSY;
    tick();
    check("t6_ren_before", 32'(ramREN), 32'd1);
    do_reset();
    check("t6_ren_after", 32'(ramREN), 32'd0);
    iREN = 1; iaddr = 32'h84; ramstate = RS_ACCESS; ramload = 32'h76543210;
    tick();
    check("t6_no_stale", 32'(ihit), 32'd0);
    tick();
    check("t6_ihit", 32'(ihit), 32'd1);
    check("t6_iload", iload, 32'h76543210);
    idle_inputs();
    tick();

    // Random traffic against the model.
    for (int n = 0; n < 2400; n++) begin
      if (n % 400 == 399) begin
        do_reset();
      end else begin
        iREN = 1'($urandom);
        dREN = 1'($urandom);
        dWEN = ($urandom % 3) == 0;
        iaddr = $urandom; daddr = $urandom; dstore = $urandom; ramload = $urandom;
        r = int'($urandom % 20);
        ramstate = (r == 0) ? RS_ERROR : (r < 9) ? RS_ACCESS : (r < 14) ? RS_BUSY : RS_FREE;
        tick();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
